// File: rtl/fwd_pkg.sv
// Purpose : shared forwarding-select encoding between hazard detection and operand resolution.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
//
// Contents: fwd_sel_e (3-bit choice code), XLEN_DEF, fwd_sel_reserved() helper.
package fwd_pkg;

  localparam int XLEN_DEF = 32;

  // Codes above FWD_WB are reserved; consumers fall back to the register file.
  typedef enum logic [2:0] {
    FWD_RF      = 3'b000,
    FWD_EXU     = 3'b001,
    FWD_MEM_ALU = 3'b010,
    FWD_MEM_LD  = 3'b011,
    FWD_WB      = 3'b100
  } fwd_sel_e;

  function automatic logic fwd_sel_reserved(input logic [2:0] choice);
    return (choice > 3'(FWD_WB));
  endfunction

endpackage

// File: rtl/fwd_operand_mux.sv
// Purpose : resolve one operand from its forwarding choice code and five candidate sources.
// Latency : combinational.
// Backpr. : none; pure datapath select.
//
// Ports:
//   i_choice   3-bit forwarding select (fwd_sel_e encoding)
//   i_used     operand is actually read by the instruction
//   i_rf .. i_wb  candidate sources: regfile, EXU ALU, MEM ALU, MEM load, WB
//   o_data     selected operand value
//   o_err      used operand carried a reserved code
module fwd_operand_mux
  import fwd_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [2:0]      i_choice,
  input  logic            i_used,
  input  logic [XLEN-1:0] i_rf,
  input  logic [XLEN-1:0] i_exu_alu,
  input  logic [XLEN-1:0] i_mem_alu,
  input  logic [XLEN-1:0] i_mem_ld,
  input  logic [XLEN-1:0] i_wb,
  output logic [XLEN-1:0] o_data,
  output logic            o_err
);

  always_comb begin
    o_data = i_rf;
    case (i_choice)
      FWD_EXU:     o_data = i_exu_alu;
      FWD_MEM_ALU: o_data = i_mem_alu;
      FWD_MEM_LD:  o_data = i_mem_ld;
      FWD_WB:      o_data = i_wb;
      default:     o_data = i_rf;  // FWD_RF and reserved codes
    endcase
  end

  // An unused operand is allowed to carry garbage in its choice field.
  assign o_err = i_used & fwd_sel_reserved(i_choice);

endmodule

// File: rtl/fwd_operand_stage.sv
// Purpose : resolve rs1/rs2 from forwarding choices, detect load-use, own the IDU->EXU operand register.
// Latency : one cycle from IDU acceptance to EXU_in_valid.
// Backpr. : EXU_ready=0 holds a valid slot and stalls IDU; load-use inserts one bubble; flush overrides both.
//
// Ports:
//   clk, rst_n                       core clock, async active-low reset
//   IDU_valid, IDU_rs*_used          instruction presence and operand usage
//   IDU_rs*_choice                   forwarding selects (fwd_pkg::fwd_sel_e)
//   IDU_rf_rs*, EXU_alu_result, MEM_alu_result, MEM_load_data, WB_wdata   candidate sources
//   EXU_mem_ren, EXU_ready, flush    hazard / handshake / redirect controls
//   IDU_stall                        combinational hold request to IDU
//   EXU_in_valid, EXU_op1, EXU_op2   registered operand slot
//   sel_err                          registered: used operand had a reserved choice code
// Optional (FWD_STATS_EN defined): parameter STAT_W and saturating outputs
//   stat_stall_cnt (load-use stall cycles) and stat_fwd_cnt (accepted instructions using forwarding).
module fwd_operand_stage
  import fwd_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
`ifdef FWD_STATS_EN
  ,
  parameter int STAT_W = 32
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            IDU_valid,
  input  logic            IDU_rs1_used,
  input  logic            IDU_rs2_used,
  input  logic [2:0]      IDU_rs1_choice,
  input  logic [2:0]      IDU_rs2_choice,
  input  logic [XLEN-1:0] IDU_rf_rs1,
  input  logic [XLEN-1:0] IDU_rf_rs2,
  input  logic [XLEN-1:0] EXU_alu_result,
  input  logic [XLEN-1:0] MEM_alu_result,
  input  logic [XLEN-1:0] MEM_load_data,
  input  logic [XLEN-1:0] WB_wdata,
  input  logic            EXU_mem_ren,
  input  logic            EXU_ready,
  input  logic            flush,
  output logic            IDU_stall,
  output logic            EXU_in_valid,
  output logic [XLEN-1:0] EXU_op1,
  output logic [XLEN-1:0] EXU_op2,
  output logic            sel_err
`ifdef FWD_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_stall_cnt,
  output logic [STAT_W-1:0] stat_fwd_cnt
`endif
);

  logic            r_exu_in_valid;
  logic [XLEN-1:0] r_exu_op1;
  logic [XLEN-1:0] r_exu_op2;
  logic            r_sel_err;

  logic [XLEN-1:0] w_op1;
  logic [XLEN-1:0] w_op2;
  logic            w_err1;
  logic            w_err2;
  logic            w_load_use;
  logic            w_slot_busy;
  logic            w_accept;

  fwd_operand_mux #(.XLEN(XLEN)) u_mux_rs1 (
    .i_choice  (IDU_rs1_choice),
    .i_used    (IDU_rs1_used),
    .i_rf      (IDU_rf_rs1),
    .i_exu_alu (EXU_alu_result),
    .i_mem_alu (MEM_alu_result),
    .i_mem_ld  (MEM_load_data),
    .i_wb      (WB_wdata),
    .o_data    (w_op1),
    .o_err     (w_err1)
  );

  fwd_operand_mux #(.XLEN(XLEN)) u_mux_rs2 (
    .i_choice  (IDU_rs2_choice),
    .i_used    (IDU_rs2_used),
    .i_rf      (IDU_rf_rs2),
    .i_exu_alu (EXU_alu_result),
    .i_mem_alu (MEM_alu_result),
    .i_mem_ld  (MEM_load_data),
    .i_wb      (WB_wdata),
    .o_data    (w_op2),
    .o_err     (w_err2)
  );

  // A load in EXU has no result yet; any used operand pointing at EXU must wait
  // one cycle, after which hazard detection re-encodes it as FWD_MEM_LD.
  assign w_load_use = IDU_valid & r_exu_in_valid & EXU_mem_ren &
                      ((IDU_rs1_used & (IDU_rs1_choice == 3'(FWD_EXU))) |
                       (IDU_rs2_used & (IDU_rs2_choice == 3'(FWD_EXU))));

  assign w_slot_busy = r_exu_in_valid & ~EXU_ready;

  // Flush squashes the IDU instruction anyway, so holding it would be pointless.
  assign IDU_stall = (w_load_use | w_slot_busy) & ~flush;

  assign w_accept = ~flush & ~w_slot_busy & ~w_load_use;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exu_in_valid <= 1'b0;
      r_exu_op1      <= '0;
      r_exu_op2      <= '0;
      r_sel_err      <= 1'b0;
    end else if (flush) begin
      // Operand data is left in place; only the valid/err qualifiers matter.
      r_exu_in_valid <= 1'b0;
      r_sel_err      <= 1'b0;
    end else if (w_slot_busy) begin
      // EXU has not taken the current slot: hold everything.
      r_exu_in_valid <= r_exu_in_valid;
    end else if (w_load_use) begin
      // Bubble into EXU while IDU holds the dependent instruction.
      r_exu_in_valid <= 1'b0;
      r_sel_err      <= 1'b0;
    end else begin
      r_exu_in_valid <= IDU_valid;
      r_exu_op1      <= w_op1;
      r_exu_op2      <= w_op2;
      r_sel_err      <= IDU_valid & (w_err1 | w_err2);
    end
  end

  assign EXU_in_valid = r_exu_in_valid;
  assign EXU_op1      = r_exu_op1;
  assign EXU_op2      = r_exu_op2;
  assign sel_err      = r_sel_err;

`ifdef FWD_STATS_EN
  logic [STAT_W-1:0] r_stat_stall_cnt;
  logic [STAT_W-1:0] r_stat_fwd_cnt;
  logic              w_uses_fwd;

  // Any non-regfile code on a used operand counts, reserved codes included.
  assign w_uses_fwd = (IDU_rs1_used & (IDU_rs1_choice != 3'(FWD_RF))) |
                      (IDU_rs2_used & (IDU_rs2_choice != 3'(FWD_RF)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_stall_cnt <= '0;
      r_stat_fwd_cnt   <= '0;
    end else begin
      if (w_load_use && !flush && (r_stat_stall_cnt != '1)) begin
        r_stat_stall_cnt <= r_stat_stall_cnt + STAT_W'(1);
      end
      if (w_accept && IDU_valid && w_uses_fwd && (r_stat_fwd_cnt != '1)) begin
        r_stat_fwd_cnt <= r_stat_fwd_cnt + STAT_W'(1);
      end
    end
  end

  assign stat_stall_cnt = r_stat_stall_cnt;
  assign stat_fwd_cnt   = r_stat_fwd_cnt;
`endif

endmodule

// File: tb/tb_fwd_operand_stage.sv
// Purpose : self-checking bench for fwd_operand_stage (directed steps followed by random traffic).
// Latency : n/a.
// Backpr. : drives EXU_ready low and flush to exercise hold and squash paths.
module tb_fwd_operand_stage;
  localparam int XLEN = 32;
`ifdef FWD_STATS_EN
  localparam int STAT_W = 4;
  localparam int STAT_MAX = (1 << STAT_W) - 1;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            IDU_valid, IDU_rs1_used, IDU_rs2_used;
  logic [2:0]      IDU_rs1_choice, IDU_rs2_choice;
  logic [XLEN-1:0] IDU_rf_rs1, IDU_rf_rs2;
  logic [XLEN-1:0] EXU_alu_result, MEM_alu_result, MEM_load_data, WB_wdata;
  logic            EXU_mem_ren, EXU_ready, flush;
  logic            IDU_stall, EXU_in_valid, sel_err;
  logic [XLEN-1:0] EXU_op1, EXU_op2;
`ifdef FWD_STATS_EN
  logic [STAT_W-1:0] stat_stall_cnt, stat_fwd_cnt;
`endif

  always #5 clk = ~clk;

  fwd_operand_stage #(
    .XLEN(XLEN)
`ifdef FWD_STATS_EN
    , .STAT_W(STAT_W)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .IDU_valid(IDU_valid), .IDU_rs1_used(IDU_rs1_used), .IDU_rs2_used(IDU_rs2_used),
    .IDU_rs1_choice(IDU_rs1_choice), .IDU_rs2_choice(IDU_rs2_choice),
    .IDU_rf_rs1(IDU_rf_rs1), .IDU_rf_rs2(IDU_rf_rs2),
    .EXU_alu_result(EXU_alu_result), .MEM_alu_result(MEM_alu_result),
    .MEM_load_data(MEM_load_data), .WB_wdata(WB_wdata),
    .EXU_mem_ren(EXU_mem_ren), .EXU_ready(EXU_ready), .flush(flush),
    .IDU_stall(IDU_stall), .EXU_in_valid(EXU_in_valid),
    .EXU_op1(EXU_op1), .EXU_op2(EXU_op2), .sel_err(sel_err)
`ifdef FWD_STATS_EN
    , .stat_stall_cnt(stat_stall_cnt), .stat_fwd_cnt(stat_fwd_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: what EXU should be holding, plus event counts.
  logic            m_valid;
  logic [XLEN-1:0] m_op1, m_op2;
  logic            m_err;
  int              m_stall_cnt, m_fwd_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Source table indexed by choice code; anything past the table reads the regfile.
  function automatic logic [XLEN-1:0] pick(input logic [2:0] c, input logic [XLEN-1:0] rf);
    logic [XLEN-1:0] src [5];
    src[0] = rf;
    src[1] = EXU_alu_result;
    src[2] = MEM_alu_result;
    src[3] = MEM_load_data;
    src[4] = WB_wdata;
    return (int'(c) < 5) ? src[int'(c)] : rf;
  endfunction

  // An operand is stuck if it wants the EXU result while EXU holds an in-flight load.
  function automatic logic needs_load(input logic used, input logic [2:0] c);
    return used && (c == 3'd1) && IDU_valid && m_valid && EXU_mem_ren;
  endfunction

  function automatic int sat_inc(input int v);
`ifdef FWD_STATS_EN
    return (v >= STAT_MAX) ? STAT_MAX : v + 1;
`else
    return v + 1;
`endif
  endfunction

  task automatic set_instr(input logic v, input logic u1, input logic [2:0] c1,
                           input logic u2, input logic [2:0] c2);
    IDU_valid = v; IDU_rs1_used = u1; IDU_rs1_choice = c1;
    IDU_rs2_used = u2; IDU_rs2_choice = c2;
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_op1 = '0; m_op2 = '0; m_err = 1'b0;
    m_stall_cnt = 0; m_fwd_cnt = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"}, 32'(EXU_in_valid), 32'(m_valid));
    chk({tag, ".op1"}, EXU_op1, m_op1);
    chk({tag, ".op2"}, EXU_op2, m_op2);
    chk({tag, ".err"}, 32'(sel_err), 32'(m_err));
`ifdef FWD_STATS_EN
    chk({tag, ".stall_cnt"}, 32'(stat_stall_cnt), m_stall_cnt);
    chk({tag, ".fwd_cnt"}, 32'(stat_fwd_cnt), m_fwd_cnt);
`endif
  endtask

  // Called at posedge+1 with inputs already set; ends at the following posedge+1.
  task automatic step(input string tag);
    logic lu, busy, accepted;
    #1;
    lu   = needs_load(IDU_rs1_used, IDU_rs1_choice) || needs_load(IDU_rs2_used, IDU_rs2_choice);
    busy = m_valid && !EXU_ready;
    chk({tag, ".stall"}, 32'(IDU_stall), 32'((lu || busy) && !flush));
    accepted = !flush && !busy && !lu;
    @(posedge clk);
    if (lu && !flush) m_stall_cnt = sat_inc(m_stall_cnt);
    if (accepted && IDU_valid &&
        ((IDU_rs1_used && IDU_rs1_choice != 3'd0) || (IDU_rs2_used && IDU_rs2_choice != 3'd0)))
      m_fwd_cnt = sat_inc(m_fwd_cnt);
    if (flush || (!busy && lu)) begin
      m_valid = 1'b0;
      m_err   = 1'b0;
    end else if (accepted) begin
      m_valid = IDU_valid;
      m_op1   = pick(IDU_rs1_choice, IDU_rf_rs1);
      m_op2   = pick(IDU_rs2_choice, IDU_rf_rs2);
      m_err   = IDU_valid && ((IDU_rs1_used && IDU_rs1_choice > 3'd4) ||
                              (IDU_rs2_used && IDU_rs2_choice > 3'd4));
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic rand_sources();
    IDU_rf_rs1 = $urandom; IDU_rf_rs2 = $urandom;
    EXU_alu_result = $urandom; MEM_alu_result = $urandom;
    MEM_load_data = $urandom; WB_wdata = $urandom;
  endtask

  initial begin
    rst_n = 1'b0;
    set_instr(0, 0, 0, 0, 0);
    rand_sources();
    EXU_mem_ren = 0; EXU_ready = 1; flush = 0;
    model_reset();
    #2;
    check_outputs("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Forwarding from MEM ALU and WB.
    rand_sources();
    MEM_alu_result = 32'h1234; WB_wdata = 32'hBEEF;
    set_instr(1, 1, 3'b010, 1, 3'b100);
    step("fwd_sel");
    chk("fwd_sel.op1_const", EXU_op1, 32'h1234);
    chk("fwd_sel.op2_const", EXU_op2, 32'hBEEF);

    // Load-use: one bubble, then the load data via MEM_LD.
    rand_sources();
    EXU_mem_ren = 1;
    set_instr(1, 0, 3'b000, 1, 3'b001);
    step("lu_stall");
    chk("lu_bubble", 32'(EXU_in_valid), 32'd0);
    rand_sources();
    EXU_mem_ren = 0; MEM_load_data = 32'hCAFE;
    set_instr(1, 0, 3'b000, 1, 3'b011);
    step("lu_resolve");
    chk("lu_resolve.op2_const", EXU_op2, 32'hCAFE);

    // Unused operands never stall or flag errors.
    rand_sources();
    EXU_mem_ren = 1;
    set_instr(1, 0, 3'b001, 1, 3'b000);
    step("unused_exu");
    EXU_mem_ren = 0;
    set_instr(1, 0, 3'b111, 1, 3'b000);
    step("unused_rsvd");
    chk("unused_rsvd.err_const", 32'(sel_err), 32'd0);
    set_instr(1, 1, 3'b110, 0, 3'b000);
    step("used_rsvd");

    // Backpressure for three cycles, then flush.
    EXU_ready = 0;
    for (int i = 0; i < 3; i++) begin
      rand_sources();
      set_instr(1, 1, 3'($urandom_range(0, 4)), 1, 3'($urandom_range(0, 4)));
      step("bp_hold");
    end
    flush = 1;
    step("bp_flush");
    flush = 0; EXU_ready = 1;

    // Async reset in the middle of a cycle while the slot is valid.
    set_instr(1, 1, 3'b000, 1, 3'b000);
    step("pre_reset");
    #2; rst_n = 1'b0;
    #1; model_reset();
    check_outputs("mid_reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    rand_sources();
    set_instr(1, 1, 3'b100, 0, 3'b000);
    step("post_reset");

    // Two load-use stalls interleaved with forwarded instructions.
    EXU_mem_ren = 1; rand_sources(); set_instr(1, 1, 3'b001, 0, 3'b000); step("cnt_lu1");
    EXU_mem_ren = 0; rand_sources(); set_instr(1, 1, 3'b011, 0, 3'b000); step("cnt_f2");
    EXU_mem_ren = 1; rand_sources(); set_instr(1, 0, 3'b000, 1, 3'b001); step("cnt_lu2");
    EXU_mem_ren = 0; rand_sources(); set_instr(1, 0, 3'b000, 1, 3'b011); step("cnt_f3");
    rand_sources(); set_instr(1, 1, 3'b100, 1, 3'b000); step("cnt_f4");
    rand_sources(); set_instr(1, 1, 3'b010, 1, 3'b001); step("cnt_f5");
`ifdef FWD_STATS_EN
    chk("stats.stall_const", 32'(stat_stall_cnt), 32'd2);
    chk("stats.fwd_const", 32'(stat_fwd_cnt), 32'd5);
`endif

    // Random traffic; small counters saturate well within this run.
    for (int i = 0; i < 400; i++) begin
      rand_sources();
      set_instr(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 2) == 0) ? 3'b001 : 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 2) == 0) ? 3'b001 : 3'($urandom_range(0, 7)));
      EXU_mem_ren = 1'($urandom_range(0, 1));
      EXU_ready   = 1'($urandom_range(0, 3) != 0);
      flush       = 1'($urandom_range(0, 15) == 0);
      step("rand");
    end
`ifdef FWD_STATS_EN
    chk("stats.fwd_saturated", 32'(stat_fwd_cnt), STAT_MAX);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_operand_stage.md
Name: fwd_operand_stage

Overview:
- Consumer side of the forwarding-select encoding produced by hazard detection.
- Takes the per-operand 3-bit choice codes and all candidate data sources, and resolves rs1/rs2 operand values for the instruction in IDU.
- Detects load-use hazards that forwarding cannot cover, and inserts one bubble when it finds one.
- Owns the IDU->EXU operand pipeline register, with valid/ready handshake and flush.

Parameters:
- XLEN, 32, datapath width.
- STAT_W, 32, width of the optional statistics counters.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- IDU_valid  in  1  IDU holds a valid decoded instruction.
- IDU_rs1_used  in  1  instruction reads rs1.
- IDU_rs2_used  in  1  instruction reads rs2.
- IDU_rs1_choice  in  3  forwarding select for rs1.
- IDU_rs2_choice  in  3  forwarding select for rs2.
- IDU_rf_rs1  in  XLEN  register-file read data, rs1.
- IDU_rf_rs2  in  XLEN  register-file read data, rs2.
- EXU_alu_result  in  XLEN  ALU result currently in EXU.
- MEM_alu_result  in  XLEN  ALU result currently in MEM.
- MEM_load_data  in  XLEN  load data returned in MEM.
- WB_wdata  in  XLEN  write-back data.
- EXU_mem_ren  in  1  instruction currently in EXU is a load.
- EXU_ready  in  1  EXU accepts a new instruction this cycle.
- flush  in  1  squash the IDU and EXU operand slots (branch redirect).
- IDU_stall  out  1  IDU must hold its instruction this cycle.
- EXU_in_valid  out  1  registered operand slot valid.
- EXU_op1  out  XLEN  registered resolved rs1 operand.
- EXU_op2  out  XLEN  registered resolved rs2 operand.
- sel_err  out  1  registered: a used operand presented reserved code 101-111.

Behaviour:
- Choice decode, per operand, combinational:
  - 000 -> IDU_rf
  - 001 -> EXU_alu_result
  - 010 -> MEM_alu_result
  - 011 -> MEM_load_data
  - 100 -> WB_wdata
  - 101-111 -> IDU_rf, and sets the error condition if that operand is used.
- load_use = IDU_valid & EXU_in_valid & EXU_mem_ren & ((IDU_rs1_used & rs1_choice==001) | (IDU_rs2_used & rs2_choice==001)).
- slot_busy = EXU_in_valid & ~EXU_ready.
- IDU_stall = (load_use | slot_busy) & ~flush, combinational.
- Register update priority, highest first:
  - reset -> EXU_in_valid=0, EXU_op1=0, EXU_op2=0, sel_err=0.
  - flush -> EXU_in_valid=0, sel_err=0; operands hold.
  - slot_busy -> all registers hold.
  - load_use -> bubble: EXU_in_valid=0, operands hold, sel_err=0.
  - otherwise -> EXU_op1/op2 = resolved values, EXU_in_valid=IDU_valid, sel_err = IDU_valid & error condition.
- Latency: one cycle from IDU acceptance to EXU_in_valid.
- Load-use costs exactly one bubble. The next cycle the load is in MEM, hazard detection re-encodes the operand as 011, and the stall clears.
- An unused operand never causes a stall or an error, whatever its code.
- Flush in the same cycle as load_use or slot_busy: flush wins and IDU_stall=0.
- Reset asserted mid-transfer clears the slot immediately (asynchronously).
- IDU_valid=0: the slot loads invalid and no stall is raised.

Optional Feature:
- Macro FWD_STATS_EN.
- Defined: adds outputs stat_stall_cnt and stat_fwd_cnt, each STAT_W bits.
  - stat_stall_cnt increments on each cycle with load_use & ~flush.
  - stat_fwd_cnt increments on each accepted valid instruction with at least one used operand choice != 000.
  - Both counters saturate at all-ones and reset to 0.
- Undefined: neither port nor counters exist; behaviour is otherwise identical.

Decomposition:
- Package fwd_pkg holds:
  - typedef enum logic[2:0] fwd_sel_e: FWD_RF=000, FWD_EXU=001, FWD_MEM_ALU=010, FWD_MEM_LD=011, FWD_WB=100.
  - localparam XLEN_DEF=32.
- The same package is shared with hazard detection so both ends agree on the encoding.
- Sub-module fwd_operand_mux: purely combinational; one choice, one used bit and five sources in; data and err out. Instantiated twice.

Test Plan:
- Reset: rst_n=0 mid-cycle with EXU_in_valid=1 -> all outputs 0 immediately; after release, first accepted instruction appears next edge.
- Forward select: rs1_choice=010 with MEM_alu_result=0x1234, rs2_choice=100 with WB_wdata=0xBEEF, EXU_ready=1 -> next cycle EXU_op1=0x1234, EXU_op2=0xBEEF, EXU_in_valid=1.
- Load-use: EXU_mem_ren=1 with rs2_choice=001 and rs2_used=1 -> IDU_stall=1 for exactly one cycle and a bubble enters EXU. Then rs2_choice=011 with MEM_load_data=0xCAFE -> EXU_op2=0xCAFE.
- Unused operand: rs1_used=0 with rs1_choice=001 and load in EXU -> no stall; rs1_choice=111 with rs1_used=0 -> sel_err=0.
- Backpressure plus flush: EXU_ready=0 for 3 cycles -> slot holds and IDU_stall=1. Then flush=1 -> EXU_in_valid=0 next edge and IDU_stall=0 in the flush cycle.
- FWD_STATS_EN: 2 load-use stalls and 5 forwarded instructions -> stat_stall_cnt=2, stat_fwd_cnt=5; preset counter to all-ones -> it stays saturated.
